// File: rtl/norm_pipe_arbiter.sv
// norm_pipe_arbiter
//   Shares one fixed-latency RNS normalization pipeline between two
//   requesters. Each cycle at most one operand is issued (round-robin between
//   requesters that hold credit). A tag shift register follows each operand
//   through the pipeline, so its result can be steered into that requester's
//   result FIFO. Credit is counted as queued results plus results still in the
//   pipeline, so a FIFO can never overflow and a stalled consumer blocks only
//   its own requester.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   reqN_valid/ready/digits  operand handshake, 8 x 18-bit RNS digits
//   pipe_dig_out             registered operand into the pipeline (zero = bubble)
//   pipe_dig_in/sign_in      pipeline result, valid PIPE_LAT edges after issue
//   rspN_valid/ready         result handshake, FIFO head on rspN_digits/sign
//   busy                     any operation in flight or any result queued
//
// PIPE_LAT must be >= 2 and DEPTH a power of two >= 2.
module norm_pipe_arbiter #(
  parameter int PIPE_LAT = 12,
  parameter int DEPTH    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [143:0] req0_digits,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [143:0] req1_digits,
  output logic [143:0] pipe_dig_out,
  input  logic [143:0] pipe_dig_in,
  input  logic [1:0]   pipe_sign_in,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [143:0] rsp0_digits,
  output logic [1:0]   rsp0_sign,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [143:0] rsp1_digits,
  output logic [1:0]   rsp1_sign,
  output logic         busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 146;

  logic [1:0]                    req_valid;
  logic [1:0]                    rsp_ready;
  logic [1:0]                    eligible;
  logic [1:0]                    cand;
  logic [1:0]                    grant;
  logic [1:0]                    push;
  logic [1:0]                    pop;
  logic [1:0]                    not_empty;
  logic                          leave_valid;
  logic                          leave_id;

  logic                          last_grant_q, last_grant_d;
  logic [PIPE_LAT-1:0]           tag_valid_q, tag_valid_d;
  logic [PIPE_LAT-1:0]           tag_id_q, tag_id_d;
  logic [143:0]                  pipe_dig_q, pipe_dig_d;
  logic [1:0][CW-1:0]            inflight_q, inflight_d;
  logic [1:0][CW-1:0]            count_q, count_d;
  logic [1:0][PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0][PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [1:0][DEPTH-1:0][EW-1:0] mem_q, mem_d;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // The tag at the far end of the shift register belongs to the result that is
  // on pipe_dig_in/pipe_sign_in this cycle.
  assign leave_valid = tag_valid_q[PIPE_LAT-1];
  assign leave_id    = tag_id_q[PIPE_LAT-1];

  // Arbitration. Gating with rst_n keeps ready low while reset is held even
  // though the grant is purely combinational.
  always_comb begin
    eligible = '0;
    for (int n = 0; n < 2; n++) begin
      eligible[n] = ({1'b0, count_q[n]} + {1'b0, inflight_q[n]}) < (CW+1)'(DEPTH);
    end
    cand = req_valid & eligible & {2{rst_n}};
    if (cand == 2'b11) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end else begin
      grant = cand;
    end
  end

  // Next-state for issue, tag tracking, credit and the two result FIFOs.
  always_comb begin
    last_grant_d = last_grant_q;
    pipe_dig_d   = '0;
    if (grant[1]) begin
      last_grant_d = 1'b1;
      pipe_dig_d   = req1_digits;
    end else if (grant[0]) begin
      last_grant_d = 1'b0;
      pipe_dig_d   = req0_digits;
    end

    tag_valid_d = {tag_valid_q[PIPE_LAT-2:0], |grant};
    tag_id_d    = {tag_id_q[PIPE_LAT-2:0], grant[1]};

    push = {leave_valid & leave_id, leave_valid & ~leave_id};

    inflight_d = inflight_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;
    not_empty  = '0;
    pop        = '0;
    for (int n = 0; n < 2; n++) begin
      not_empty[n]  = count_q[n] != '0;
      pop[n]        = not_empty[n] & rsp_ready[n];
      inflight_d[n] = inflight_q[n] + CW'(grant[n]) - CW'(push[n]);
      count_d[n]    = count_q[n] + CW'(push[n]) - CW'(pop[n]);
      wr_ptr_d[n]   = wr_ptr_q[n] + PW'(push[n]);
      rd_ptr_d[n]   = rd_ptr_q[n] + PW'(pop[n]);
      if (push[n]) begin
        mem_d[n][wr_ptr_q[n]] = {pipe_sign_in, pipe_dig_in};
      end
    end
  end

  // Control state; last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      tag_valid_q  <= '0;
      tag_id_q     <= '0;
      pipe_dig_q   <= '0;
      inflight_q   <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      tag_valid_q  <= tag_valid_d;
      tag_id_q     <= tag_id_d;
      pipe_dig_q   <= pipe_dig_d;
      inflight_q   <= inflight_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // FIFO storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign req0_ready   = grant[0];
  assign req1_ready   = grant[1];
  assign pipe_dig_out = pipe_dig_q;
  assign rsp0_valid   = not_empty[0];
  assign rsp1_valid   = not_empty[1];
  assign {rsp0_sign, rsp0_digits} = mem_q[0][rd_ptr_q[0]];
  assign {rsp1_sign, rsp1_digits} = mem_q[1][rd_ptr_q[1]];
  assign busy         = (|tag_valid_q) | (|not_empty);

  a_no_overflow0: assert property (@(posedge clk) disable iff (!rst_n)
    !(push[0] && count_q[0] == CW'(DEPTH)));
  a_no_overflow1: assert property (@(posedge clk) disable iff (!rst_n)
    !(push[1] && count_q[1] == CW'(DEPTH)));

endmodule

// File: tb/tb_norm_pipe_arbiter.sv
// tb_norm_pipe_arbiter
//   Directed bench for norm_pipe_arbiter with PIPE_LAT=12, DEPTH=4. A pass-
//   through pipeline model returns each operand unchanged with a sign taken
//   from the low bits of digits 0 and 1, so results are traceable by value.
//   Inputs are driven just after the falling edge; outputs are sampled there.
module tb_norm_pipe_arbiter;

  localparam int PIPE_LAT = 12;
  localparam int STAGES   = PIPE_LAT - 1;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [143:0] req0_digits, req1_digits;
  logic [143:0] pipe_dig_out, pipe_dig_in;
  logic [1:0]   pipe_sign_in;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [143:0] rsp0_digits, rsp1_digits;
  logic [1:0]   rsp0_sign, rsp1_sign;
  logic         busy;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [143:0] q0[$];
  logic [143:0] q1[$];

  norm_pipe_arbiter #(.PIPE_LAT(PIPE_LAT), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_digits(req0_digits),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_digits(req1_digits),
    .pipe_dig_out(pipe_dig_out), .pipe_dig_in(pipe_dig_in), .pipe_sign_in(pipe_sign_in),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_digits(rsp0_digits),
    .rsp0_sign(rsp0_sign),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_digits(rsp1_digits),
    .rsp1_sign(rsp1_sign),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] sign_of(input logic [143:0] d);
    return d[1:0] ^ d[19:18];
  endfunction

  function automatic logic [143:0] pack8(input logic [17:0] d0, d1, d2, d3,
                                         d4, d5, d6, d7);
    return {d7, d6, d5, d4, d3, d2, d1, d0};
  endfunction

  function automatic logic [143:0] vec(input int k);
    return {18'(k * 3), 108'd0, 18'(k)};
  endfunction

  // Pipeline model: pipe_dig_out is the first register, STAGES more follow,
  // so the result is on pipe_dig_in during the cycle before edge E+PIPE_LAT.
  logic [143:0] stage_dig [STAGES];
  logic [1:0]   stage_sign [STAGES];
  always @(posedge clk) begin
    stage_dig[0]  <= pipe_dig_out;
    stage_sign[0] <= sign_of(pipe_dig_out);
    for (int i = 1; i < STAGES; i++) begin
      stage_dig[i]  <= stage_dig[i-1];
      stage_sign[i] <= stage_sign[i-1];
    end
  end
  assign pipe_dig_in  = stage_dig[STAGES-1];
  assign pipe_sign_in = stage_sign[STAGES-1];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    rsp0_ready  = 1'b0;
    rsp1_ready  = 1'b0;
    req0_digits = '0;
    req1_digits = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_digits = vec(7); req1_digits = vec(9);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    tick();
    tick();
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
    end
    tests_run++;
    if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
      tests_failed++; $display("[TB] FAIL reset_valid_busy: got %b expected 000", {rsp0_valid, rsp1_valid, busy});
    end
    tests_run++;
    if (pipe_dig_out !== 144'd0) begin
      tests_failed++; $display("[TB] FAIL reset_pipe_out: got %h expected 0", pipe_dig_out);
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      tests_failed++; $display("[TB] FAIL reset_first_grant: got %b expected 01", {req1_ready, req0_ready});
    end
    tick();
    tests_run++;
    if (pipe_dig_out !== vec(7)) begin
      tests_failed++; $display("[TB] FAIL reset_first_transfer: got %h expected %h", pipe_dig_out, vec(7));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_single_op();
    logic [143:0] v;
    v = pack8(18'h08115, 18'h04b59, 18'h13d2e, 18'h03ac8,
              18'h243e4, 18'h09147, 18'h24bca, 18'h36c7d);
    apply_reset();
    req0_valid = 1'b1; req0_digits = v;
    #1;
    tests_run++;
    if (req0_ready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL single_ready: got %b expected 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0; req0_digits = '0;
    tests_run++;
    if (pipe_dig_out !== v) begin
      tests_failed++; $display("[TB] FAIL single_pipe_out: got %h expected %h", pipe_dig_out, v);
    end
    repeat (11) tick();
    tests_run++;
    if ({rsp0_valid, busy, pipe_dig_out} !== {1'b0, 1'b1, 144'd0}) begin
      tests_failed++; $display("[TB] FAIL single_before_latency: got valid=%b busy=%b out=%h expected valid=0 busy=1 out=0", rsp0_valid, busy, pipe_dig_out);
    end
    tick();
    tests_run++;
    if ({rsp0_valid, rsp1_valid} !== 2'b10) begin
      tests_failed++; $display("[TB] FAIL single_rsp_valid: got %b expected 10", {rsp0_valid, rsp1_valid});
    end
    tests_run++;
    if ({rsp0_sign, rsp0_digits} !== {2'b00, v}) begin
      tests_failed++; $display("[TB] FAIL single_rsp_data: got %b/%h expected 00/%h", rsp0_sign, rsp0_digits, v);
    end
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    tests_run++;
    if ({rsp0_valid, busy} !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL single_after_pop: got valid/busy %b expected 00", {rsp0_valid, busy});
    end
  endtask

  task automatic test_contention();
    logic [143:0] exp_d;
    apply_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    q0.delete(); q1.delete();
    for (int i = 0; i < 8; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_digits = vec(256 + i); req1_digits = vec(512 + i);
      #1;
      tests_run++;
      if ({req1_ready, req0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        tests_failed++; $display("[TB] FAIL contention_grant_%0d: got %b expected %b", i, {req1_ready, req0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      if (i % 2 == 0) q0.push_back(vec(256 + i));
      else            q1.push_back(vec(512 + i));
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (rsp0_valid) begin
        exp_d = (q0.size() > 0) ? q0.pop_front() : '1;
        tests_run++;
        if ({rsp0_sign, rsp0_digits} !== {sign_of(exp_d), exp_d}) begin
          tests_failed++; $display("[TB] FAIL contention_rsp0: got %h expected %h", rsp0_digits, exp_d);
        end
      end
      if (rsp1_valid) begin
        exp_d = (q1.size() > 0) ? q1.pop_front() : '1;
        tests_run++;
        if ({rsp1_sign, rsp1_digits} !== {sign_of(exp_d), exp_d}) begin
          tests_failed++; $display("[TB] FAIL contention_rsp1: got %h expected %h", rsp1_digits, exp_d);
        end
      end
      tick();
    end
    tests_run++;
    if (q0.size() + q1.size() != 0) begin
      tests_failed++; $display("[TB] FAIL contention_missing: got %0d results outstanding expected 0", q0.size() + q1.size());
    end
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    apply_reset();
    rsp1_ready = 1'b1;
    req0_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req0_digits = vec(768 + i);
      #1;
      tests_run++;
      if (req0_ready !== ((i < 4) ? 1'b1 : 1'b0)) begin
        tests_failed++; $display("[TB] FAIL backpressure_ready_%0d: got %b expected %b", i, req0_ready, (i < 4) ? 1'b1 : 1'b0);
      end
      tick();
    end
    req1_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req1_digits = vec(1024 + i);
      #1;
      tests_run++;
      if ({req1_ready, req0_ready} !== 2'b10) begin
        tests_failed++; $display("[TB] FAIL backpressure_req1_%0d: got %b expected 10", i, {req1_ready, req0_ready});
      end
      tick();
    end
    req1_valid = 1'b0;
    repeat (7) tick();
    tests_run++;
    if ({rsp0_valid, req0_ready, rsp0_digits} !== {1'b1, 1'b0, vec(768)}) begin
      tests_failed++; $display("[TB] FAIL backpressure_full: got valid=%b ready=%b head=%h expected 1 0 %h", rsp0_valid, req0_ready, rsp0_digits, vec(768));
    end
    rsp0_ready = 1'b1;
    #1;
    tests_run++;
    if (req0_ready !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL backpressure_before_pop: got %b expected 0", req0_ready);
    end
    tick();
    tests_run++;
    if ({req0_ready, rsp0_digits} !== {1'b1, vec(769)}) begin
      tests_failed++; $display("[TB] FAIL backpressure_after_pop: got ready=%b head=%h expected 1 %h", req0_ready, rsp0_digits, vec(769));
    end
    req0_valid = 1'b0;
    repeat (4) tick();
    tests_run++;
    if (rsp0_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL backpressure_drain: got %b expected 0", rsp0_valid);
    end
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic test_fifo_boundary();
    apply_reset();
    req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req1_digits = vec(1280 + i);
      tick();
    end
    req1_valid = 1'b0;
    repeat (11) tick();
    tests_run++;
    if ({rsp1_valid, rsp1_digits} !== {1'b1, vec(1280)}) begin
      tests_failed++; $display("[TB] FAIL fifo_three_head: got %b/%h expected 1/%h", rsp1_valid, rsp1_digits, vec(1280));
    end
    rsp1_ready = 1'b1;
    tick();
    rsp1_ready = 1'b0;
    tick();
    for (int i = 1; i < 4; i++) begin
      tests_run++;
      if ({rsp1_valid, rsp1_digits} !== {1'b1, vec(1280 + i)}) begin
        tests_failed++; $display("[TB] FAIL fifo_order_%0d: got %b/%h expected 1/%h", i, rsp1_valid, rsp1_digits, vec(1280 + i));
      end
      rsp1_ready = 1'b1;
      tick();
    end
    tests_run++;
    if (rsp1_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL fifo_empty: got %b expected 0", rsp1_valid);
    end
    rsp1_ready = 1'b0;
  endtask

  task automatic test_extremes();
    logic [143:0] ext;
    ext = pack8(18'h0ffff, 18'h1312c, 18'h1cb90, 18'h2b3fa,
                18'h3ff8a, 18'h3ffa0, 18'h3ffa2, 18'h3ffb4);
    apply_reset();
    req0_valid = 1'b1; req0_digits = '0;
    req1_valid = 1'b1; req1_digits = ext;
    tick();
    req0_valid = 1'b0;
    tick();
    req1_valid = 1'b0;
    repeat (12) tick();
    tests_run++;
    if ({rsp0_valid, rsp0_sign, rsp0_digits} !== {1'b1, 2'b00, 144'd0}) begin
      tests_failed++; $display("[TB] FAIL extremes_zero: got %b/%b/%h expected 1/00/0", rsp0_valid, rsp0_sign, rsp0_digits);
    end
    tests_run++;
    if ({rsp1_valid, rsp1_sign, rsp1_digits} !== {1'b1, 2'b11, ext}) begin
      tests_failed++; $display("[TB] FAIL extremes_max: got %b/%b/%h expected 1/11/%h", rsp1_valid, rsp1_sign, rsp1_digits, ext);
    end
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_digits = vec(1536 + i); req1_digits = vec(1792 + i);
      tick();
    end
    tests_run++;
    if ({busy, pipe_dig_out} !== {1'b1, vec(1540)}) begin
      tests_failed++; $display("[TB] FAIL midflight_before: got busy=%b out=%h expected 1 %h", busy, pipe_dig_out, vec(1540));
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({pipe_dig_out, busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== {144'd0, 5'b00000}) begin
      tests_failed++; $display("[TB] FAIL midflight_reset: got out=%h flags=%b expected 0 00000", pipe_dig_out, {busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 14; c++) begin
      tick();
      tests_run++;
      if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
        tests_failed++; $display("[TB] FAIL midflight_quiet_%0d: got %b expected 000", c, {rsp0_valid, rsp1_valid, busy});
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog timeout");
  end

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_fifo_boundary();
    test_extremes();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
